// File: rtl/gauss_stats_pkg.sv
// Shared types and widths for the windowed Gaussian statistics block.
package gauss_stats_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, CALC, REPORT} state_t;
  localparam int SAMPLE_W   = 16;
  localparam int VAR_W      = 32;
  localparam int LOG2_N_DEF = 10;
endpackage

// File: rtl/gauss_var_calc.sv
// Combinational mean/variance from window sums: floor-shift mean, mean-square minus squared mean.
module gauss_var_calc
  import gauss_stats_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic signed [SAMPLE_W+LOG2_N-1:0]   sum,
  input  logic        [2*SAMPLE_W+LOG2_N-1:0] sumsq,
  output logic signed [SAMPLE_W-1:0]          mean,
  output logic        [VAR_W-1:0]             variance
);
  localparam int DIFF_W = 2*SAMPLE_W + LOG2_N + 2;

  logic        [2*SAMPLE_W+LOG2_N-1:0] msq;
  logic signed [2*SAMPLE_W-1:0]        mean_sq;
  logic signed [DIFF_W-1:0]            diff;

  // Negative results come from floor rounding of the mean; they are clamped to zero.
  function automatic logic [VAR_W-1:0] clamp_sat(input logic signed [DIFF_W-1:0] d);
    if (d[DIFF_W-1])
      return '0;
    else if (|d[DIFF_W-2:VAR_W])
      return '1;
    else
      return d[VAR_W-1:0];
  endfunction

  always_comb begin
    mean     = SAMPLE_W'(sum >>> LOG2_N);
    msq      = sumsq >> LOG2_N;
    mean_sq  = mean * mean;
    diff     = $signed({2'b00, msq}) - DIFF_W'(mean_sq);
    variance = clamp_sat(diff);
  end
endmodule

// File: rtl/gauss_stats.sv
// Collects a window of 2^LOG2_N signed samples and reports mean, variance, min and max.
module gauss_stats
  import gauss_stats_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] mean,
  output logic        [VAR_W-1:0]    variance,
  output logic signed [SAMPLE_W-1:0] min_s,
  output logic signed [SAMPLE_W-1:0] max_s,
  output logic                       busy
);
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int SQ_W  = 2*SAMPLE_W + LOG2_N;

  state_t                      state;
  logic signed [SUM_W-1:0]     sum;
  logic        [SQ_W-1:0]      sumsq;
  logic        [LOG2_N-1:0]    count;
  logic signed [SAMPLE_W-1:0]  min_acc, max_acc;
  logic signed [2*SAMPLE_W-1:0] sq;
  logic signed [SAMPLE_W-1:0]  calc_mean;
  logic        [VAR_W-1:0]     calc_var;
  logic                        arm;

  assign sq  = in * in;
  assign arm = start && ((state == IDLE) || (state == REPORT && out_ready));

  gauss_var_calc #(.LOG2_N(LOG2_N)) u_calc (
    .sum      (sum),
    .sumsq    (sumsq),
    .mean     (calc_mean),
    .variance (calc_var)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mean      <= '0;
      variance  <= '0;
      min_s     <= '0;
      max_s     <= '0;
      sum       <= '0;
      sumsq     <= '0;
      count     <= '0;
      min_acc   <= '0;
      max_acc   <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        ACCUM: begin
          if (in_valid) begin
            sum   <= sum + SUM_W'(in);
            sumsq <= sumsq + SQ_W'($unsigned(sq));
            count <= count + 1'b1;
            if (in < min_acc) min_acc <= in;
            if (in > max_acc) max_acc <= in;
            if (&count) begin
              state    <= CALC;
              in_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          mean      <= calc_mean;
          variance  <= calc_var;
          min_s     <= min_acc;
          max_s     <= max_acc;
          state     <= REPORT;
          out_valid <= 1'b1;
        end
        REPORT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
      endcase
      // Arming wins over the REPORT exit so a handshake with start chains straight into ACCUM.
      if (arm) begin
        state     <= ACCUM;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b1;
        sum       <= '0;
        sumsq     <= '0;
        count     <= '0;
        min_acc   <= 16'sh7FFF;
        max_acc   <= -16'sh8000;
      end
    end
  end
endmodule
